// File: rtl/risc_v_wb_sched_if.sv
// Result-source and register-file write-port bundle for the write-back scheduler.
interface risc_v_wb_sched_if #(
  parameter int unsigned WIDTH1 = 32,
  parameter int unsigned WIDTH2 = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [WIDTH2-1:0] alu_rd;
  logic [WIDTH1-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [WIDTH2-1:0] mem_rd;
  logic [WIDTH1-1:0] mem_data;
  logic              wr;
  logic [WIDTH2-1:0] waddr;
  logic [WIDTH1-1:0] wdata;

  // Scheduler side: consumes result beats, drives the write port.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output wr, waddr, wdata
  );

  // Source/register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  wr, waddr, wdata
  );
endinterface

// File: rtl/risc_v_wb_sched.sv
// Write-back scheduler: buffers ALU and load results, arbitrates the single
// register-file write port with ALU anti-starvation, and tracks pending writes.
module risc_v_wb_sched #(
  parameter int unsigned WIDTH1       = 32,
  parameter int unsigned WIDTH2       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  risc_v_wb_sched_if.slave  bus,
  input  logic              iss_valid,
  input  logic [WIDTH2-1:0] iss_rd,
  output logic              iss_stall,
  input  logic [WIDTH2-1:0] chk_addr1,
  input  logic [WIDTH2-1:0] chk_addr2,
  output logic              busy1,
  output logic              busy2
);

  localparam int unsigned NREG = 1 << WIDTH2;
  localparam int unsigned SW   = 4;
  localparam int unsigned ALU  = 0;
  localparam int unsigned MEM  = 1;

  typedef struct packed {
    logic [WIDTH2-1:0] rd;
    logic [WIDTH1-1:0] data;
  } beat_t;

  beat_t             src_beat [2];
  logic [1:0]        src_valid;
  beat_t             fifo_q   [2][2];
  logic [1:0]        cnt_q    [2];
  logic              rp_q     [2];
  logic              wp_q     [2];
  beat_t             head     [2];
  logic [1:0]        rdy;
  logic [1:0]        ne;
  logic [1:0]        push;
  logic [1:0]        pop;
  beat_t             gnt_beat;
  logic              grant;
  logic [SW-1:0]     starve_q;
  logic              wr_q;
  logic [WIDTH2-1:0] waddr_q;
  logic [WIDTH1-1:0] wdata_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  // Source beats and per-FIFO status; ready depends on registered count only.
  always_comb begin
    src_valid     = {bus.mem_valid, bus.alu_valid};
    src_beat[ALU] = '{rd: bus.alu_rd, data: bus.alu_data};
    src_beat[MEM] = '{rd: bus.mem_rd, data: bus.mem_data};
    for (int s = 0; s < 2; s++) begin
      rdy[s]  = (cnt_q[s] < 2'd2);
      ne[s]   = (cnt_q[s] != 2'd0);
      head[s] = fifo_q[s][rp_q[s]];
      push[s] = src_valid[s] && rdy[s];
    end
  end

  // Arbitration: mem has priority unless the ALU head has starved long enough.
  always_comb begin
    pop      = 2'b00;
    gnt_beat = head[ALU];
    if (ne[MEM] && !(ne[ALU] && (starve_q >= SW'(STARVE_LIMIT)))) begin
      pop[MEM] = 1'b1;
      gnt_beat = head[MEM];
    end else if (ne[ALU]) begin
      pop[ALU] = 1'b1;
    end
    grant = |pop;
  end

  // Two-entry FIFOs, one per source.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        cnt_q[s] <= 2'd0;
        rp_q[s]  <= 1'b0;
        wp_q[s]  <= 1'b0;
      end else begin
        if (push[s]) begin
          fifo_q[s][wp_q[s]] <= src_beat[s];
          wp_q[s]            <= ~wp_q[s];
        end
        if (pop[s]) begin
          rp_q[s] <= ~rp_q[s];
        end
        cnt_q[s] <= cnt_q[s] + 2'(push[s]) - 2'(pop[s]);
      end
    end
  end

  // Registered write port; x0 grants are consumed without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q <= grant && (gnt_beat.rd != '0);
      if (grant) begin
        waddr_q <= gnt_beat.rd;
        wdata_q <= gnt_beat.data;
      end
    end
  end

  // Counts consecutive lost arbitrations of a waiting ALU head, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (ne[ALU] && !pop[ALU]) begin
      starve_q <= (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end else begin
      starve_q <= '0;
    end
  end

  // Scoreboard next state: commit clears, issue sets, set wins on collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard lookups include the register file's same-cycle write bypass.
  always_comb begin
    iss_stall = busy_q[iss_rd]    && !(wr_q && (waddr_q == iss_rd));
    busy1     = busy_q[chk_addr1] && !(wr_q && (waddr_q == chk_addr1));
    busy2     = busy_q[chk_addr2] && !(wr_q && (waddr_q == chk_addr2));
  end

  assign bus.alu_ready = rdy[ALU];
  assign bus.mem_ready = rdy[MEM];
  assign bus.wr        = wr_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_risc_v_wb_sched.sv
// Self-checking bench for risc_v_wb_sched: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_risc_v_wb_sched;

  localparam int unsigned W1  = 32;
  localparam int unsigned W2  = 5;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          iss_valid;
  logic [W2-1:0] iss_rd;
  logic          iss_stall;
  logic [W2-1:0] chk_addr1;
  logic [W2-1:0] chk_addr2;
  logic          busy1;
  logic          busy2;

  risc_v_wb_sched_if #(.WIDTH1(W1), .WIDTH2(W2)) bus ();

  risc_v_wb_sched #(.WIDTH1(W1), .WIDTH2(W2), .STARVE_LIMIT(LIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  // Clock generation.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W2-1:0] rd;
    logic [W1-1:0] data;
  } mbeat_t;

  mbeat_t        aq[$];
  mbeat_t        mq[$];
  int            starve;
  bit            mbusy [32];
  logic          m_wr;
  logic [W2-1:0] m_waddr;
  logic [W1-1:0] m_wdata;
  bit            acc_a;
  bit            acc_m;

  function automatic bit m_pend(input logic [W2-1:0] r);
    return (r != 0) && mbusy[r] && !(m_wr && (m_waddr == r));
  endfunction

  task automatic model_check();
    check("alu_ready", bus.alu_ready, aq.size() < 2);
    check("mem_ready", bus.mem_ready, mq.size() < 2);
    check("wr", bus.wr, m_wr);
    if (m_wr) begin
      check("waddr", bus.waddr, m_waddr);
      check("wdata", bus.wdata, m_wdata);
    end
    check("iss_stall", iss_stall, m_pend(iss_rd));
    check("busy1", busy1, m_pend(chk_addr1));
    check("busy2", busy2, m_pend(chk_addr2));
  endtask

  task automatic model_step();
    mbeat_t g;
    mbeat_t nb;
    bit     gr;
    bit     ga;
    bit     a_ne;
    if (reset) begin
      aq.delete();
      mq.delete();
      starve = 0;
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
      m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
      acc_a = 1'b0; acc_m = 1'b0;
    end else begin
      acc_a = bus.alu_valid && (aq.size() < 2);
      acc_m = bus.mem_valid && (mq.size() < 2);
      a_ne  = (aq.size() > 0);
      gr = 1'b0; ga = 1'b0;
      g.rd = '0; g.data = '0;
      if (mq.size() > 0 && !(a_ne && starve >= int'(LIM))) begin
        g = mq.pop_front(); gr = 1'b1;
      end else if (a_ne) begin
        g = aq.pop_front(); gr = 1'b1; ga = 1'b1;
      end
      starve = (a_ne && !ga) ? ((starve < 15) ? starve + 1 : 15) : 0;
      if (m_wr) mbusy[m_waddr] = 1'b0;
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      m_wr = gr && (g.rd != 0);
      if (gr) begin
        m_waddr = g.rd;
        m_wdata = g.data;
      end
      if (acc_a) begin nb.rd = bus.alu_rd; nb.data = bus.alu_data; aq.push_back(nb); end
      if (acc_m) begin nb.rd = bus.mem_rd; nb.data = bus.mem_data; mq.push_back(nb); end
    end
  endtask

  // One cycle: settle, compare against model, clock, advance model, return at negedge.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_alu(input bit v, input logic [W2-1:0] rd, input logic [W1-1:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic set_mem(input bit v, input logic [W2-1:0] rd, input logic [W1-1:0] d);
    bus.mem_valid = v; bus.mem_rd = rd; bus.mem_data = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            iv;
    logic [W2-1:0] ir;
    bit            av;
    logic [W2-1:0] ard;
    logic [W1-1:0] ad;
    logic [W2-1:0] c1;
    logic [W2-1:0] c2;
    bit            ewr;
    logic [W2-1:0] ewa;
    logic [W1-1:0] ewd;
    bit            eb1;
    bit            eb2;
    bit            est;
  } vec_t;

  vec_t vq[$];

  task automatic row(input bit iv, input logic [W2-1:0] ir, input bit av,
                     input logic [W2-1:0] ard, input logic [W1-1:0] ad,
                     input logic [W2-1:0] c1, input logic [W2-1:0] c2,
                     input bit ewr, input logic [W2-1:0] ewa, input logic [W1-1:0] ewd,
                     input bit eb1, input bit eb2, input bit est);
    vec_t v;
    v.iv = iv; v.ir = ir; v.av = av; v.ard = ard; v.ad = ad; v.c1 = c1; v.c2 = c2;
    v.ewr = ewr; v.ewa = ewa; v.ewd = ewd; v.eb1 = eb1; v.eb2 = eb2; v.est = est;
    vq.push_back(v);
  endtask

  initial begin
    int            exp_seq [10];
    int            nine_cnt;
    int            wcnt;
    logic [W2-1:0] mrd;
    logic [W2-1:0] r;

    reset = 1'b1; iss_valid = 1'b0; iss_rd = '0; chk_addr1 = '0; chk_addr2 = '0;
    set_alu(0, 0, 0); set_mem(0, 0, 0);
    @(posedge clk); model_step(); @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wr", bus.wr, 1'b0);
    check("rst_waddr", bus.waddr, '0);
    check("rst_wdata", bus.wdata, '0);
    check("rst_alu_ready", bus.alu_ready, 1'b1);
    check("rst_mem_ready", bus.mem_ready, 1'b1);

    // Single ALU beat, x0 handling, set/clear collision.
    //  iv ir  av ard ad            c1 c2 ewr ewa ewd           b1 b2 st
    row(1, 7,  0, 0,  32'h0,        7, 0, 0,  0,  32'h0,        0, 0, 0);
    row(0, 0,  1, 7,  32'hDEADBEEF, 7, 7, 0,  0,  32'h0,        1, 1, 0);
    row(0, 0,  0, 0,  32'h0,        7, 3, 0,  0,  32'h0,        1, 0, 0);
    row(0, 0,  0, 0,  32'h0,        7, 7, 1,  7,  32'hDEADBEEF, 0, 0, 0);
    row(0, 0,  0, 0,  32'h0,        7, 0, 0,  0,  32'h0,        0, 0, 0);
    row(1, 0,  1, 0,  32'h1234,     0, 7, 0,  0,  32'h0,        0, 0, 0);
    row(0, 0,  0, 0,  32'h0,        0, 7, 0,  0,  32'h0,        0, 0, 0);
    row(0, 0,  0, 0,  32'h0,        0, 7, 0,  0,  32'h0,        0, 0, 0);
    row(1, 4,  0, 0,  32'h0,        4, 0, 0,  0,  32'h0,        0, 0, 0);
    row(0, 0,  1, 4,  32'hA5A5,     4, 0, 0,  0,  32'h0,        1, 0, 0);
    row(0, 0,  0, 0,  32'h0,        4, 4, 0,  0,  32'h0,        1, 1, 0);
    row(1, 4,  0, 0,  32'h0,        4, 4, 1,  4,  32'hA5A5,     0, 0, 0);
    row(0, 0,  0, 0,  32'h0,        4, 4, 0,  0,  32'h0,        1, 1, 0);
    row(0, 4,  0, 0,  32'h0,        4, 7, 0,  0,  32'h0,        1, 0, 1);

    foreach (vq[i]) begin
      iss_valid = vq[i].iv; iss_rd = vq[i].ir;
      set_alu(vq[i].av, vq[i].ard, vq[i].ad);
      chk_addr1 = vq[i].c1; chk_addr2 = vq[i].c2;
      #1;
      check("vec_wr", bus.wr, vq[i].ewr);
      if (vq[i].ewr) begin
        check("vec_waddr", bus.waddr, vq[i].ewa);
        check("vec_wdata", bus.wdata, vq[i].ewd);
      end
      check("vec_busy1", busy1, vq[i].eb1);
      check("vec_busy2", busy2, vq[i].eb2);
      check("vec_stall", iss_stall, vq[i].est);
      check("vec_alu_ready", bus.alu_ready, 1'b1);
      tick();
    end
    iss_valid = 1'b0; iss_rd = '0; set_alu(0, 0, 0);

    // Priority and order: mem drains first, then ALU, back to back.
    set_alu(1, 1, 32'h101); set_mem(1, 3, 32'h303); tick();
    set_alu(1, 2, 32'h102); set_mem(1, 4, 32'h304); tick();
    set_alu(0, 0, 0); set_mem(0, 0, 0);
    exp_seq[0] = 3; exp_seq[1] = 4; exp_seq[2] = 1; exp_seq[3] = 2;
    for (int k = 0; k < 4; k++) begin
      check("order_wr", bus.wr, 1'b1);
      check("order_waddr", bus.waddr, exp_seq[k]);
      tick();
    end
    check("order_wr_end", bus.wr, 1'b0);
    tick();

    // Starvation: ALU holds 9 then 10 under a continuous mem stream.
    exp_seq[0] = 20; exp_seq[1] = 21; exp_seq[2] = 22; exp_seq[3] = 23; exp_seq[4] = 9;
    exp_seq[5] = 24; exp_seq[6] = 25; exp_seq[7] = 26; exp_seq[8] = 27; exp_seq[9] = 10;
    nine_cnt = 0;
    mrd = 5'd20;
    set_alu(1, 9, 32'h55); set_mem(1, mrd, 32'h2000 + 32'(mrd)); tick();
    if (acc_m) mrd = mrd + 5'd1;
    set_alu(1, 10, 32'h66);
    for (int k = 0; k < 10; k++) begin
      set_mem(1, mrd, 32'h2000 + 32'(mrd));
      tick();
      if (acc_m) mrd = mrd + 5'd1;
      if (acc_a) set_alu(0, 0, 0);
      check("starve_wr", bus.wr, 1'b1);
      check("starve_waddr", bus.waddr, exp_seq[k]);
      if (bus.wr && bus.waddr == 9) nine_cnt++;
    end
    set_mem(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.wr && bus.waddr == 9) nine_cnt++;
    end
    check("starve_nine_once", nine_cnt, 1);

    // Reset mid-operation with buffered beats and a pending register.
    iss_valid = 1'b1; iss_rd = 5;
    set_alu(1, 12, 32'hC); set_mem(1, 11, 32'hB); tick();
    iss_valid = 1'b0; iss_rd = '0;
    tick(); tick();
    #1;
    check("pre_rst_alu_full", bus.alu_ready, 1'b0);
    reset = 1'b1; tick();
    reset = 1'b0; set_alu(0, 0, 0); set_mem(0, 0, 0); chk_addr1 = 5;
    #1;
    check("midrst_alu_ready", bus.alu_ready, 1'b1);
    check("midrst_mem_ready", bus.mem_ready, 1'b1);
    check("midrst_wr", bus.wr, 1'b0);
    check("midrst_busy5", busy1, 1'b0);
    wcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.wr) wcnt++;
    end
    check("midrst_no_writes", wcnt, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (!bus.alu_valid || acc_a)
        set_alu($urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), $urandom);
      if (!bus.mem_valid || acc_m)
        set_mem($urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), $urandom);
      reset     = ($urandom_range(0, 199) == 0);
      chk_addr1 = 5'($urandom_range(0, 31));
      chk_addr2 = 5'($urandom_range(0, 31));
      r = 5'($urandom_range(0, 31));
      iss_rd = r;
      iss_valid = ($urandom_range(0, 2) == 0) && !m_pend(r);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
